wb_master_sequencer: RTL and testbench

// Wishbone classic single-cycle master; sits upstream of the Wishbone slave

---
 rtl/wb_master_sequencer.sv | 166 ++++++++++++++++
 tb/tb_wb_master_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_sequencer.sv
// wb_master_sequencer
// ---------------------------------------------------------------------------
// Wishbone classic single-cycle bus master. Each command taken on the cmd
// channel runs exactly one read or write bus cycle. The result comes back on
// the rsp channel as read data, or as an error flag if the slave never acks.
//
// Handshake rule, for both cmd and rsp: a transfer happens on the rising edge
// where valid && ready are both 1. The valid side holds its payload stable
// until that edge. The ready side may change ready at any time.
//
// Ports
//   clk_i, rst_i             clock; synchronous active-high reset
//   cmd_valid/cmd_ready      command channel (cmd_we, cmd_adr, cmd_wdata)
//   rsp_valid/rsp_ready      response channel (rsp_rdata, rsp_err)
//   cyc_o, stb_o, we_o       Wishbone master control
//   adr_o, dat_o             Wishbone address / write data (dat_o = 0 on reads)
//   dat_i, ack_i             Wishbone read data / acknowledge
//   state_o                  current FSM state (IDLE=0, REQUEST=1, RESPOND=2)
// ---------------------------------------------------------------------------
module wb_master_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_adr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Counter value on the last REQUEST cycle allowed before the abort.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d = ST_REQUEST;
                    cyc_d   = 1'b1;
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    // Reads drive zero on the data bus rather than stale data.
                    dat_d   = cmd_we ? cmd_wdata : '0;
                    cnt_d   = '0;
                end
            end
            ST_REQUEST: begin
                // The ack check comes first, so an ack on the final allowed
                // cycle beats the timeout.
                if (ack_i) begin
                    state_d     = ST_RESPOND;
                    cyc_d       = 1'b0;
                    rdata_d     = we_q ? '0 : dat_i;
                    err_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                    state_d     = ST_RESPOND;
                    cyc_d       = 1'b0;
                    rdata_d     = '0;
                    err_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESPOND: begin
                // The FSM stays here for at least one cycle. That guarantees
                // stb is low for at least one cycle between bus cycles.
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    // In a classic single master, cyc and stb are the same signal, so one
    // flop drives both.
    assign cmd_ready = cmd_ready_q;
    assign cyc_o     = cyc_q;
    assign stb_o     = cyc_q;
    assign we_o      = we_q;
    assign adr_o     = adr_q;
    assign dat_o     = dat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_wb_master_sequencer.sv
// Testbench for wb_master_sequencer: write, read-back, timeout, backpressure
// with back-to-back commands, ack/timeout collision, and reset mid-cycle.
// A behavioural Wishbone slave acks after a programmable number of strobe
// cycles. Expected responses go into exp_q as each command is issued.
module tb_wb_master_sequencer;

  logic        clk;
  logic        rst_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic [1:0]  state_o;

  wb_master_sequencer #(
    .TIMEOUT_CYCLES(16),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .state_o(state_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- behavioural slave ----------------
  logic        slave_en;
  int          ack_delay;   // ack on the ack_delay-th strobe cycle
  int          sc;
  logic [31:0] slave_mem [16];

  assign ack_i = slave_en && stb_o && (sc == ack_delay - 1);
  assign dat_i = ack_i ? slave_mem[adr_o[5:2]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (rst_i) begin
      sc <= 0;
      for (int i = 0; i < 16; i++) slave_mem[i] <= 32'h0;
    end else begin
      if (stb_o && !ack_i) sc <= sc + 1;
      else sc <= 0;
      if (ack_i && we_o) slave_mem[adr_o[5:2]] <= dat_o;
    end
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];     // {err, rdata}
  logic [31:0] ref_mem [16];
  logic [32:0] e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          accept_cyc;

  // ---------------- driver tasks ----------------
  // Called 1 time unit after a rising edge. Returns 1 time unit after the
  // accept edge.
  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                          output bit ok);
    int n;
    ok = 0;
    cmd_we = we; cmd_adr = adr; cmd_wdata = wdata; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (cmd_ready) begin
      @(posedge clk); #1;
      accept_cyc = cyc_cnt;
      ok = 1;
    end
    cmd_valid = 1'b0;
  endtask

  // Waits, with a bound, until rsp_valid is seen. While waiting it records
  // how the bus behaves.
  task automatic wait_rsp(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                          output int lat, output int stb_cyc, output int stb_rises,
                          output bit bus_ok, output bit ok);
    int n;
    logic prev_stb;
    stb_cyc = 0; stb_rises = 0; bus_ok = 1; prev_stb = 1'b0; n = 0;
    while (!rsp_valid && n < 100) begin
      if (stb_o) begin
        stb_cyc++;
        if (!prev_stb) stb_rises++;
        if (cyc_o !== 1'b1 || we_o !== we || adr_o !== adr ||
            dat_o !== (we ? wdata : 32'h0)) bus_ok = 0;
      end
      prev_stb = stb_o;
      @(posedge clk); #1; n++;
    end
    ok  = rsp_valid;
    lat = cyc_cnt - accept_cyc;
    if (rsp_valid && (stb_o || cyc_o)) bus_ok = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %0b exp 1", cmd_ready); end
    n_checks++; if ({cyc_o, stb_o, we_o, rsp_valid, rsp_err} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %05b exp 00000", {cyc_o, stb_o, we_o, rsp_valid, rsp_err}); end
    n_checks++; if ({adr_o, dat_o, rsp_rdata} !== 96'h0) begin n_fail++; $display("FAIL reset_data: adr %h dat %h rdata %h exp 0", adr_o, dat_o, rsp_rdata); end
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", state_o); end
  endtask

  task automatic test_write();
    bit ok, bus_ok; int lat, sc_n, rises;
    slave_en = 1'b1; ack_delay = 3;
    ref_mem[1] = 32'hA5A5_0001;
    exp_q.push_back({1'b0, 32'h0});
    send_cmd(1'b1, 32'h4, 32'hA5A5_0001, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL write_accept: cmd_ready never 1"); end
    wait_rsp(1'b1, 32'h4, 32'hA5A5_0001, lat, sc_n, rises, bus_ok, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL write_rsp_timeout: no rsp_valid"); end
    n_checks++; if (rises !== 1) begin n_fail++; $display("FAIL write_stb_pulses: got %0d exp 1", rises); end
    n_checks++; if (sc_n !== 3) begin n_fail++; $display("FAIL write_stb_len: got %0d exp 3", sc_n); end
    n_checks++; if (!bus_ok) begin n_fail++; $display("FAIL write_bus_stable: we/adr/dat not held, got 0 exp 1"); end
    e = exp_q.pop_front();
    n_checks++; if ({rsp_err, rsp_rdata} !== e) begin n_fail++; $display("FAIL write_rsp: got err %0b rdata %h exp err %0b rdata %h", rsp_err, rsp_rdata, e[32], e[31:0]); end
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL write_done: rsp_valid %0b cmd_ready %0b exp 0 1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_read_back();
    bit ok, bus_ok; int lat, sc_n, rises;
    slave_en = 1'b1; ack_delay = 3;
    exp_q.push_back({1'b0, ref_mem[1]});
    send_cmd(1'b0, 32'h4, 32'hFFFF_FFFF, ok);
    wait_rsp(1'b0, 32'h4, 32'hFFFF_FFFF, lat, sc_n, rises, bus_ok, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL read_rsp_timeout: no rsp_valid"); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL read_latency: got %0d exp 3", lat); end
    n_checks++; if (!bus_ok) begin n_fail++; $display("FAIL read_bus: dat_o nonzero or bus unstable, got 0 exp 1"); end
    e = exp_q.pop_front();
    n_checks++; if ({rsp_err, rsp_rdata} !== e) begin n_fail++; $display("FAIL read_rsp: got err %0b rdata %h exp err %0b rdata %h", rsp_err, rsp_rdata, e[32], e[31:0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    bit ok, bus_ok; int lat, sc_n, rises;
    slave_en = 1'b0;
    exp_q.push_back({1'b1, 32'h0});
    send_cmd(1'b0, 32'h8, 32'h0, ok);
    wait_rsp(1'b0, 32'h8, 32'h0, lat, sc_n, rises, bus_ok, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL timeout_rsp: no rsp_valid"); end
    n_checks++; if (sc_n !== 16) begin n_fail++; $display("FAIL timeout_stb_len: got %0d exp 16", sc_n); end
    e = exp_q.pop_front();
    n_checks++; if ({rsp_err, rsp_rdata} !== e) begin n_fail++; $display("FAIL timeout_rsp_val: got err %0b rdata %h exp err %0b rdata %h", rsp_err, rsp_rdata, e[32], e[31:0]); end
    @(posedge clk); #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_cmd_ready: got %0b exp 1", cmd_ready); end
  endtask

  task automatic test_back_to_back();
    bit ok, bus_ok, stable, rdy_low, stb_low; int lat, sc_n, rises;
    logic [31:0] hold_rdata; logic hold_err;
    slave_en = 1'b1; ack_delay = 3;
    rsp_ready = 1'b0;
    ref_mem[2] = 32'h1234_5678;
    exp_q.push_back({1'b0, 32'h0});
    send_cmd(1'b1, 32'h8, 32'h1234_5678, ok);
    wait_rsp(1'b1, 32'h8, 32'h1234_5678, lat, sc_n, rises, bus_ok, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_rsp1: no rsp_valid"); end
    // The second command is held valid while the first response is stalled.
    exp_q.push_back({1'b0, ref_mem[2]});
    cmd_we = 1'b0; cmd_adr = 32'h8; cmd_wdata = 32'h0; cmd_valid = 1'b1;
    e = exp_q.pop_front();
    n_checks++; if ({rsp_err, rsp_rdata} !== e) begin n_fail++; $display("FAIL b2b_rsp1_val: got err %0b rdata %h exp err %0b rdata %h", rsp_err, rsp_rdata, e[32], e[31:0]); end
    hold_rdata = rsp_rdata; hold_err = rsp_err;
    stable = 1; rdy_low = 1; stb_low = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== hold_rdata || rsp_err !== hold_err) stable = 0;
      if (cmd_ready !== 1'b0) rdy_low = 0;
      if (stb_o !== 1'b0) stb_low = 0;
    end
    n_checks++; if (!stable) begin n_fail++; $display("FAIL b2b_rsp_hold: got 0 exp 1"); end
    n_checks++; if (!rdy_low) begin n_fail++; $display("FAIL b2b_cmd_ready_low: got 0 exp 1"); end
    n_checks++; if (!stb_low) begin n_fail++; $display("FAIL b2b_stb_low_stall: got 0 exp 1"); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || stb_o !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: rsp_valid %0b cmd_ready %0b stb %0b exp 0 1 0", rsp_valid, cmd_ready, stb_o); end
    send_cmd(1'b0, 32'h8, 32'h0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_accept2: cmd_ready never 1"); end
    wait_rsp(1'b0, 32'h8, 32'h0, lat, sc_n, rises, bus_ok, ok);
    e = exp_q.pop_front();
    n_checks++; if (!ok || {rsp_err, rsp_rdata} !== e) begin n_fail++; $display("FAIL b2b_rsp2: valid %0b err %0b rdata %h exp 1 %0b %h", rsp_valid, rsp_err, rsp_rdata, e[32], e[31:0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_collision();
    bit ok, bus_ok; int lat, sc_n, rises;
    slave_en = 1'b1; ack_delay = 16;
    exp_q.push_back({1'b0, ref_mem[1]});
    send_cmd(1'b0, 32'h4, 32'h0, ok);
    wait_rsp(1'b0, 32'h4, 32'h0, lat, sc_n, rises, bus_ok, ok);
    n_checks++; if (sc_n !== 16) begin n_fail++; $display("FAIL collision_stb_len: got %0d exp 16", sc_n); end
    e = exp_q.pop_front();
    n_checks++; if (!ok || {rsp_err, rsp_rdata} !== e) begin n_fail++; $display("FAIL collision_rsp: valid %0b err %0b rdata %h exp 1 %0b %h", rsp_valid, rsp_err, rsp_rdata, e[32], e[31:0]); end
    @(posedge clk); #1;
    ack_delay = 3;
  endtask

  task automatic test_reset_mid_request();
    bit ok, saw_rsp;
    slave_en = 1'b0;
    send_cmd(1'b0, 32'hC, 32'h0, ok);
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (stb_o !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_stb: got %0b exp 1", stb_o); end
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    n_checks++; if ({cyc_o, stb_o, rsp_valid, cmd_ready} !== 4'b0001) begin n_fail++; $display("FAIL midrst_after: cyc/stb/rsp_valid/cmd_ready got %04b exp 0001", {cyc_o, stb_o, rsp_valid, cmd_ready}); end
    saw_rsp = 0;
    repeat (20) begin @(posedge clk); #1; if (rsp_valid) saw_rsp = 1; end
    n_checks++; if (saw_rsp) begin n_fail++; $display("FAIL midrst_no_rsp: got rsp_valid 1 exp 0"); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_wdata = 32'h0;
    rsp_ready = 1'b1; slave_en = 1'b0; ack_delay = 3; accept_cyc = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_write();
    test_read_back();
    test_timeout();
    test_back_to_back();
    test_collision();
    test_reset_mid_request();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left exp 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
